// File: rtl/trigger_seq.sv
// trigger_seq: multi-stage level/edge trigger sequencer for the capture path.
// Optional macro TRIGSEQ_EDGE_EN adds rise/fall matching with sample history.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for arm; configuration writable
// ARMED | evaluating stage cur_stage on valid samples
// FIRED | run held high; configuration writable
module trigger_seq #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4,
  parameter int COUNT_WIDTH  = 16,
  localparam int CS_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cfg_wr,
  input  logic [CS_W-1:0]         cfg_stage,
  input  logic [2:0]              cfg_sel,
  input  logic [31:0]             cfg_data,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  output logic                    run,
  output logic                    armed,
  output logic [CS_W-1:0]         cur_stage
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  localparam logic [CS_W-1:0] LAST_STAGE = CS_W'(NUM_STAGES - 1);

  state_t                  state_q;
  logic [CS_W-1:0]         cur_q;
  logic [COUNT_WIDTH-1:0]  cnt_q;
  logic                    run_q;
  logic                    armed_q;

  logic [SAMPLE_WIDTH-1:0] mask_q  [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] value_q [NUM_STAGES];
  logic [COUNT_WIDTH-1:0]  count_q [NUM_STAGES];
  logic                    last_q  [NUM_STAGES];

`ifdef TRIGSEQ_EDGE_EN
  logic [SAMPLE_WIDTH-1:0] rise_q  [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] fall_q  [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] prev_q;
  logic                    hist_q;
`endif

  logic                    cfg_accept;
  logic                    level_ok;
  logic                    edge_ok;
  logic                    match;
  logic [COUNT_WIDTH-1:0]  req_cnt;
  logic [COUNT_WIDTH:0]    cnt_next_ext;
  logic                    stage_done;
  logic                    is_final;
  logic [COUNT_WIDTH-1:0]  cnt_sat;
  logic                    unused_cfg;

  assign unused_cfg = ^cfg_data;

  // Config is frozen while armed so a running sequence sees a stable program.
  assign cfg_accept = cfg_wr && (state_q != ST_ARMED) &&
                      (int'({1'b0, cfg_stage}) < NUM_STAGES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        mask_q[i]  <= '0;
        value_q[i] <= '0;
        count_q[i] <= '0;
        last_q[i]  <= 1'b0;
`ifdef TRIGSEQ_EDGE_EN
        rise_q[i]  <= '0;
        fall_q[i]  <= '0;
`endif
      end
    end else if (cfg_accept) begin
      case (cfg_sel)
        3'd0: mask_q[cfg_stage]  <= cfg_data[SAMPLE_WIDTH-1:0];
        3'd1: value_q[cfg_stage] <= cfg_data[SAMPLE_WIDTH-1:0];
`ifdef TRIGSEQ_EDGE_EN
        3'd2: rise_q[cfg_stage]  <= cfg_data[SAMPLE_WIDTH-1:0];
        3'd3: fall_q[cfg_stage]  <= cfg_data[SAMPLE_WIDTH-1:0];
`endif
        3'd4: begin
          count_q[cfg_stage] <= cfg_data[COUNT_WIDTH-1:0];
          last_q[cfg_stage]  <= cfg_data[31];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    level_ok = (((dataIn ^ value_q[cur_q]) & mask_q[cur_q]) == '0);
`ifdef TRIGSEQ_EDGE_EN
    // Without history an edge requirement can never be proven, so it fails.
    if (!hist_q) begin
      edge_ok = ((rise_q[cur_q] | fall_q[cur_q]) == '0);
    end else begin
      edge_ok = (((rise_q[cur_q] & ~prev_q & dataIn) == rise_q[cur_q]) &&
                 ((fall_q[cur_q] & prev_q & ~dataIn) == fall_q[cur_q]));
    end
`else
    edge_ok = 1'b1;
`endif
    match = level_ok && edge_ok;
  end

  always_comb begin
    req_cnt      = (count_q[cur_q] == '0) ? COUNT_WIDTH'(1) : count_q[cur_q];
    cnt_next_ext = {1'b0, cnt_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    stage_done   = (cnt_next_ext >= {1'b0, req_cnt});
    is_final     = last_q[cur_q] || (cur_q == LAST_STAGE);
    cnt_sat      = (&cnt_q) ? cnt_q : cnt_next_ext[COUNT_WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      armed_q <= 1'b0;
`ifdef TRIGSEQ_EDGE_EN
      prev_q  <= '0;
      hist_q  <= 1'b0;
`endif
    end else if (disarm) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      armed_q <= 1'b0;
`ifdef TRIGSEQ_EDGE_EN
      hist_q  <= 1'b0;
`endif
    end else if (arm) begin
      state_q <= ST_ARMED;
      cur_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      armed_q <= 1'b1;
`ifdef TRIGSEQ_EDGE_EN
      hist_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (valid) begin
`ifdef TRIGSEQ_EDGE_EN
            prev_q <= dataIn;
            hist_q <= 1'b1;
`endif
            if (!match) begin
              cnt_q <= '0;
            end else if (!stage_done) begin
              cnt_q <= cnt_sat;
            end else if (is_final) begin
              state_q <= ST_FIRED;
              cnt_q   <= '0;
              run_q   <= 1'b1;
              armed_q <= 1'b0;
            end else begin
              cur_q <= cur_q + CS_W'(1);
              cnt_q <= '0;
            end
          end
        end
        ST_FIRED: begin
          run_q   <= 1'b1;
          armed_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          run_q   <= 1'b0;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  assign run       = run_q;
  assign armed     = armed_q;
  assign cur_stage = cur_q;

endmodule

// File: tb/tb_trigger_seq.sv
// Self-checking bench for trigger_seq: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_trigger_seq;

`ifdef TRIGSEQ_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cfg_wr;
  logic [1:0]  cfg_stage;
  logic [2:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        arm;
  logic        disarm;
  logic        valid;
  logic [7:0]  dataIn;
  logic        run;
  logic        armed;
  logic [1:0]  cur_stage;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 idle, 1 armed, 2 fired
  int       m_mode, m_stage, m_run_len;
  bit       m_hist;
  bit [7:0] m_prev;
  bit [7:0] m_mask [4];
  bit [7:0] m_val  [4];
  bit [7:0] m_rise [4];
  bit [7:0] m_fall [4];
  int       m_need [4];
  bit       m_last [4];

  trigger_seq #(.SAMPLE_WIDTH(8), .NUM_STAGES(4), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_stage(cfg_stage),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .arm(arm), .disarm(disarm),
    .valid(valid), .dataIn(dataIn), .run(run), .armed(armed),
    .cur_stage(cur_stage)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_stage = 0; m_run_len = 0; m_hist = 0; m_prev = 0;
    for (int i = 0; i < 4; i++) begin
      m_mask[i] = 0; m_val[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
      m_need[i] = 0; m_last[i] = 0;
    end
  endtask

  function automatic bit sample_matches(input bit [7:0] d);
    bit lvl, edg;
    int s;
    s   = m_stage;
    lvl = ((d ^ m_val[s]) & m_mask[s]) == 0;
    if (!EDGE) edg = 1;
    else if (!m_hist) edg = (m_rise[s] == 0) && (m_fall[s] == 0);
    else begin
      edg = 1;
      for (int b = 0; b < 8; b++) begin
        if (m_rise[s][b] && !(m_prev[b] == 0 && d[b] == 1)) edg = 0;
        if (m_fall[s][b] && !(m_prev[b] == 1 && d[b] == 0)) edg = 0;
      end
    end
    return lvl && edg;
  endfunction

  task automatic model_cycle(input bit a, input bit d, input bit w, input int stg,
                             input int sel, input bit [31:0] wd, input bit v,
                             input bit [7:0] din);
    int need;
    if (w && m_mode != 1) begin
      case (sel)
        0: m_mask[stg] = wd[7:0];
        1: m_val[stg]  = wd[7:0];
        2: if (EDGE) m_rise[stg] = wd[7:0];
        3: if (EDGE) m_fall[stg] = wd[7:0];
        4: begin m_need[stg] = int'(wd[15:0]); m_last[stg] = wd[31]; end
        default: ;
      endcase
    end
    if (d) begin
      m_mode = 0; m_stage = 0; m_run_len = 0; m_hist = 0;
    end else if (a) begin
      m_mode = 1; m_stage = 0; m_run_len = 0; m_hist = 0;
    end else if (m_mode == 1 && v) begin
      if (sample_matches(din)) begin
        m_run_len++;
        need = (m_need[m_stage] < 1) ? 1 : m_need[m_stage];
        if (m_run_len >= need) begin
          m_run_len = 0;
          if (m_last[m_stage] || m_stage == 3) m_mode = 2;
          else m_stage++;
        end
      end else begin
        m_run_len = 0;
      end
      m_prev = din;
      m_hist = 1;
    end
  endtask

  task automatic step(input bit a, input bit d, input bit w, input int stg,
                      input int sel, input logic [31:0] wd, input bit v,
                      input logic [7:0] din);
    arm = a; disarm = d; cfg_wr = w; cfg_stage = 2'(stg); cfg_sel = 3'(sel);
    cfg_data = wd; valid = v; dataIn = din;
    @(posedge clock);
    #1;
    model_cycle(a, d, w, stg, sel, wd, v, din);
    arm = 0; disarm = 0; cfg_wr = 0; valid = 0;
    chk("run", {31'd0, run}, {31'd0, m_mode == 2});
    chk("armed", {31'd0, armed}, {31'd0, m_mode == 1});
    chk("cur_stage", {30'd0, cur_stage}, 32'(m_stage));
  endtask

  task automatic wr(input int stg, input int sel, input logic [31:0] wd);
    step(0, 0, 1, stg, sel, wd, 0, 8'h00);
  endtask

  task automatic smp(input logic [7:0] d);
    step(0, 0, 0, 0, 0, 32'd0, 1, d);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 32'd0, 0, 8'h00);
  endtask

  task automatic do_arm();
    step(1, 0, 0, 0, 0, 32'd0, 0, 8'h00);
  endtask

  task automatic do_disarm();
    step(0, 1, 0, 0, 0, 32'd0, 0, 8'h00);
  endtask

  initial begin
    bit a, d, w, v;
    int stg, sel, r;
    logic [31:0] wd;
    logic [7:0]  din;

    reset_n = 0; cfg_wr = 0; cfg_stage = 0; cfg_sel = 0; cfg_data = 0;
    arm = 0; disarm = 0; valid = 0; dataIn = 0;
    model_clear();
    #12;
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_cur_stage", {30'd0, cur_stage}, 32'd0);
    reset_n = 1;
    @(negedge clock);

    // default config: every sample completes one stage
    do_arm();
    chk("t1_armed", {31'd0, armed}, 32'd1);
    smp(8'h00); chk("t1_stage1", {30'd0, cur_stage}, 32'd1);
    smp(8'h00); chk("t1_stage2", {30'd0, cur_stage}, 32'd2);
    smp(8'h00); chk("t1_stage3", {30'd0, cur_stage}, 32'd3);
    chk("t1_norun", {31'd0, run}, 32'd0);
    smp(8'h00); chk("t1_run", {31'd0, run}, 32'd1);
    idle();     chk("t1_run_hold", {31'd0, run}, 32'd1);

    // level + consecutive count
    wr(0, 0, 32'hFF); wr(0, 1, 32'hA5); wr(0, 4, 32'h8000_0003);
    do_arm();
    chk("t2_run_cleared", {31'd0, run}, 32'd0);
    smp(8'hA5); smp(8'hA5); smp(8'h00); smp(8'hA5); smp(8'hA5);
    chk("t2_not_yet", {31'd0, run}, 32'd0);
    smp(8'hA5);
    chk("t2_fire", {31'd0, run}, 32'd1);

`ifdef TRIGSEQ_EDGE_EN
    wr(0, 0, 32'h00); wr(0, 2, 32'h01); wr(0, 4, 32'h8000_0001);
    do_arm();
    smp(8'h01); chk("t3_no_hist", {31'd0, run}, 32'd0);
    smp(8'h00); chk("t3_no_rise", {31'd0, run}, 32'd0);
    smp(8'h01); chk("t3_rise_fire", {31'd0, run}, 32'd1);
    wr(0, 2, 32'h00);
`endif

    // two-stage sequence
    wr(0, 0, 32'hF0); wr(0, 1, 32'h10); wr(0, 4, 32'h0000_0001);
    wr(1, 0, 32'h0F); wr(1, 1, 32'h03); wr(1, 4, 32'h8000_0001);
    do_arm();
    smp(8'h13); chk("t4_stage1", {30'd0, cur_stage}, 32'd1);
    chk("t4_not_yet", {31'd0, run}, 32'd0);
    smp(8'h23); chk("t4_fire", {31'd0, run}, 32'd1);

    // valid gaps, disarm clears partial count
    wr(0, 4, 32'h8000_0002);
    do_arm();
    smp(8'h13); idle(); idle(); idle();
    chk("t5_armed_gap", {31'd0, armed}, 32'd1);
    do_disarm();
    chk("t5_disarm_armed", {31'd0, armed}, 32'd0);
    chk("t5_disarm_run", {31'd0, run}, 32'd0);
    do_arm();
    smp(8'h13); chk("t5_no_fire", {31'd0, run}, 32'd0);
    idle();
    smp(8'h13); chk("t5_fire", {31'd0, run}, 32'd1);

    // write protection while armed; disarm beats arm
    do_arm();
    wr(0, 1, 32'hFF);
    smp(8'h13); smp(8'h13);
    chk("t6_old_value", {31'd0, run}, 32'd1);
    do_arm();
    step(1, 1, 0, 0, 0, 32'd0, 0, 8'h00);
    chk("t6_both_armed", {31'd0, armed}, 32'd0);
    chk("t6_both_run", {31'd0, run}, 32'd0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r   = $urandom_range(0, 99);
      a   = (r < 4);
      d   = (r >= 98);
      w   = ($urandom_range(0, 99) < 12);
      stg = $urandom_range(0, 3);
      sel = $urandom_range(0, 7);
      if (sel == 4) wd = {1'($urandom_range(0, 1)), 15'd0, 16'($urandom_range(0, 3))};
      else if (sel == 1) wd = $urandom;
      else wd = $urandom & $urandom & $urandom;
      v   = ($urandom_range(0, 99) < 65);
      din = 8'($urandom);
      step(a, d, w, stg, sel, wd, v, din);
    end

    // asynchronous reset mid-sequence wipes outputs and configuration
    wr(0, 0, 32'hFF); wr(0, 1, 32'h5A); wr(0, 4, 32'h0000_0002);
    do_arm();
    smp(8'h5A);
    #2 reset_n = 0;
    #1;
    model_clear();
    chk("areset_run", {31'd0, run}, 32'd0);
    chk("areset_armed", {31'd0, armed}, 32'd0);
    chk("areset_cur_stage", {30'd0, cur_stage}, 32'd0);
    #1 reset_n = 1;
    @(negedge clock);
    do_arm();
    smp(8'h33); smp(8'h33); smp(8'h33); smp(8'h33);
    chk("areset_cfg_lost", {31'd0, run}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
